// File: rtl/shape_sfr_arbiter_if.sv
// Request/response handshake between the configuration masters and the
// shape SFR arbiter.
//   req_valid  per-requester request, held with stable data until accepted
//   req_data   requested SFR word, requester i in bits [32*i+31:32*i]
//   req_ready  one-hot accept strobe from the arbiter
//   resp_valid one-hot, one-cycle response strobe to the granted requester
//   resp_ok    qualified by resp_valid: readback matches the request
// modport master: requester side; modport slave: arbiter side.
interface shape_sfr_arbiter_if #(
    parameter int NUM_REQ = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [NUM_REQ-1:0]    resp_valid;
    logic                  resp_ok;

    modport master (
        output req_valid,
        output req_data,
        input  req_ready,
        input  resp_valid,
        input  resp_ok
    );

    modport slave (
        input  req_valid,
        input  req_data,
        output req_ready,
        output resp_valid,
        output resp_ok
    );
endinterface

// File: rtl/shape_sfr_arbiter.sv
// Round-robin arbiter that shares the shape processor's single control-SFR
// port between NUM_REQ requesters. Each grant writes the requested word,
// reads the SFR back after READ_LATENCY cycles and reports whether the
// shape [17:16] and operation [4:0] fields now hold the requested values.
// Saturating accept/reject counters track the outcomes.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   bus (slave)           request/response handshake (see shape_sfr_arbiter_if)
//   sfr_write_o           registered write strobe, one cycle per grant
//   sfr_write_data_o      registered write word, held between writes
//   sfr_read_o            registered read strobe, one cycle per grant
//   sfr_read_data_i       readback word, valid READ_LATENCY cycles after sfr_read_o
//   busy_o                high whenever a sequence is in flight
//   ok_count_o            saturating count of matching readbacks
//   rej_count_o           saturating count of mismatching readbacks
module shape_sfr_arbiter #(
    parameter int NUM_REQ      = 2,
    parameter int READ_LATENCY = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    shape_sfr_arbiter_if.slave bus,
    output logic             sfr_write_o,
    output logic [31:0]      sfr_write_data_o,
    output logic             sfr_read_o,
    input  logic [31:0]      sfr_read_data_i,
    output logic             busy_o,
    output logic [CNT_W-1:0] ok_count_o,
    output logic [CNT_W-1:0] rej_count_o
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int WC_W = 2;
    localparam logic [WC_W-1:0] WAIT_LOAD = WC_W'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_READ  = 3'd2,
        ST_WAIT  = 3'd3,
        ST_RESP  = 3'd4
    } state_t;

    state_t               state_q, state_d;
    logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic [31:0]          cur_data_q, cur_data_d;
    logic [ID_W-1:0]      cur_id_q, cur_id_d;
    logic [WC_W-1:0]      wcnt_q, wcnt_d;
    logic                 sfr_write_q, sfr_write_d;
    logic [31:0]          sfr_write_data_q, sfr_write_data_d;
    logic                 sfr_read_q, sfr_read_d;
    logic [NUM_REQ-1:0]   resp_valid_q, resp_valid_d;
    logic                 resp_ok_q, resp_ok_d;
    logic                 busy_q, busy_d;
    logic [CNT_W-1:0]     ok_cnt_q, ok_cnt_d;
    logic [CNT_W-1:0]     rej_cnt_q, rej_cnt_d;

    logic [NUM_REQ-1:0]   grant_s;
    logic [ID_W-1:0]      gnt_id_s;
    logic                 gnt_found_s;

    // Only the shape and operation fields are compared; other bits are free.
    function automatic logic cfg_match(input logic [31:0] rd, input logic [31:0] want);
        return (rd[17:16] == want[17:16]) && (rd[4:0] == want[4:0]);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            return v;
        end else begin
            return v + CNT_W'(1'b1);
        end
    endfunction

    // Round-robin pick: first pass covers rr_ptr..NUM_REQ-1, second pass wraps to 0..rr_ptr-1.
    always_comb begin
        grant_s     = {NUM_REQ{1'b0}};
        gnt_id_s    = {ID_W{1'b0}};
        gnt_found_s = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found_s && bus.req_valid[i] && (ID_W'(i) >= rr_ptr_q)) begin
                gnt_found_s = 1'b1;
                grant_s[i]  = 1'b1;
                gnt_id_s    = ID_W'(i);
            end else begin
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!gnt_found_s && bus.req_valid[i]) begin
                gnt_found_s = 1'b1;
                grant_s[i]  = 1'b1;
                gnt_id_s    = ID_W'(i);
            end else begin
            end
        end
    end

    // Next-state logic for the write/read/wait/respond sequence.
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        cur_data_d = cur_data_q;
        cur_id_d   = cur_id_q;
        wcnt_d     = wcnt_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_found_s) begin
                    state_d  = ST_WRITE;
                    cur_id_d = gnt_id_s;
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (grant_s[i]) begin
                            cur_data_d = bus.req_data[32*i +: 32];
                        end else begin
                        end
                    end
                    if (gnt_id_s == ID_W'(NUM_REQ - 1)) begin
                        rr_ptr_d = {ID_W{1'b0}};
                    end else begin
                        rr_ptr_d = gnt_id_s + ID_W'(1'b1);
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: state_d = ST_READ;
            ST_READ: begin
                wcnt_d  = WAIT_LOAD;
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (wcnt_q == {WC_W{1'b0}}) begin
                    state_d = ST_RESP;
                end else begin
                    wcnt_d = wcnt_q - WC_W'(1'b1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output decode: registered strobes are computed from the upcoming state so they line up with it.
    always_comb begin
        sfr_write_d      = (state_d == ST_WRITE);
        sfr_read_d       = (state_d == ST_READ);
        busy_d           = (state_d != ST_IDLE);
        sfr_write_data_d = sfr_write_data_q;
        resp_valid_d     = {NUM_REQ{1'b0}};
        resp_ok_d        = 1'b0;
        ok_cnt_d         = ok_cnt_q;
        rej_cnt_d        = rej_cnt_q;
        if ((state_q == ST_IDLE) && !rst) begin
            bus.req_ready = grant_s;
        end else begin
            bus.req_ready = {NUM_REQ{1'b0}};
        end
        if (state_d == ST_WRITE) begin
            sfr_write_data_d = cur_data_d;
        end else begin
            sfr_write_data_d = sfr_write_data_q;
        end
        // Entering RESP happens only on the final WAIT edge, which is the readback sample point.
        if (state_d == ST_RESP) begin
            resp_valid_d[cur_id_q] = 1'b1;
            resp_ok_d              = cfg_match(sfr_read_data_i, cur_data_q);
        end else begin
            resp_ok_d = 1'b0;
        end
        if (state_q == ST_RESP) begin
            if (resp_ok_q) begin
                ok_cnt_d = sat_inc(ok_cnt_q);
            end else begin
                rej_cnt_d = sat_inc(rej_cnt_q);
            end
        end else begin
            ok_cnt_d = ok_cnt_q;
        end
    end

    // State and registered outputs; reset abandons any sequence in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= ST_IDLE;
            rr_ptr_q         <= {ID_W{1'b0}};
            cur_data_q       <= 32'h0000_0000;
            cur_id_q         <= {ID_W{1'b0}};
            wcnt_q           <= {WC_W{1'b0}};
            sfr_write_q      <= 1'b0;
            sfr_write_data_q <= 32'h0000_0000;
            sfr_read_q       <= 1'b0;
            resp_valid_q     <= {NUM_REQ{1'b0}};
            resp_ok_q        <= 1'b0;
            busy_q           <= 1'b0;
            ok_cnt_q         <= {CNT_W{1'b0}};
            rej_cnt_q        <= {CNT_W{1'b0}};
        end else begin
            state_q          <= state_d;
            rr_ptr_q         <= rr_ptr_d;
            cur_data_q       <= cur_data_d;
            cur_id_q         <= cur_id_d;
            wcnt_q           <= wcnt_d;
            sfr_write_q      <= sfr_write_d;
            sfr_write_data_q <= sfr_write_data_d;
            sfr_read_q       <= sfr_read_d;
            resp_valid_q     <= resp_valid_d;
            resp_ok_q        <= resp_ok_d;
            busy_q           <= busy_d;
            ok_cnt_q         <= ok_cnt_d;
            rej_cnt_q        <= rej_cnt_d;
        end
    end

    assign sfr_write_o      = sfr_write_q;
    assign sfr_write_data_o = sfr_write_data_q;
    assign sfr_read_o       = sfr_read_q;
    assign busy_o           = busy_q;
    assign ok_count_o       = ok_cnt_q;
    assign rej_count_o      = rej_cnt_q;
    assign bus.resp_valid   = resp_valid_q;
    assign bus.resp_ok      = resp_ok_q;

endmodule

// File: doc/shape_sfr_arbiter.md
# shape_sfr_arbiter

Shares the shape processor's single control-SFR write/read port between NUM_REQ requesters. Each grant runs a fixed write-then-readback sequence. It arbitrates round-robin and drives the SFR write strobe with the granted word. It then reads the control SFR back and reports per request whether the register now holds the requested shape/operation. Sits between the configuration masters and the shape processor. It also keeps saturating accept/reject statistics.

## Interface
- NUM_REQ, 2, number of requesters (2..8)
- READ_LATENCY, 1, cycles from sfr_read high to sfr_read_data valid (1..4)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  NUM_REQ  per-requester request; must stay high with stable data until accepted
- req_data  input  32*NUM_REQ  requested SFR word, requester i in bits [32*i+31:32*i]
- req_ready  output  NUM_REQ  one-hot accept strobe, combinational, only in IDLE
- resp_valid  output  NUM_REQ  one-hot, one-cycle response strobe to the granted requester
- resp_ok  output  1  qualified by resp_valid: 1 = readback matches request
- sfr_write  output  1  write strobe to shape processor, registered
- sfr_write_data  output  32  word written, registered, held until next write
- sfr_read  output  1  read strobe to shape processor, registered
- sfr_read_data  input  32  readback: [17:16] shape, [4:0] operation
- busy  output  1  high in every state except IDLE
- ok_count  output  16  accepted-request count, saturating
- rej_count  output  16  rejected-request count, saturating

## Operation
- States: IDLE, WRITE, READ, WAIT, RESP.
- IDLE: scans req_valid starting at rr_ptr and upward with wrap. The first set bit g gets req_ready[g]=1 in the same cycle.
  - On that edge: latch req_data[g] into cur_data and g into cur_id, set rr_ptr = (g+1) mod NUM_REQ, go to WRITE.
  - No valid request: stay in IDLE.
- WRITE: sfr_write=1 and sfr_write_data=cur_data for exactly this cycle. Next state is READ.
- READ: sfr_read=1 for exactly this cycle. Load wait counter with READ_LATENCY-1 and go to WAIT.
- WAIT: decrement the counter. At zero, sample sfr_read_data on that edge and go to RESP.
  - match = (rd[17:16]==cur_data[17:16]) && (rd[4:0]==cur_data[4:0]).
  - All other bits are ignored.
- RESP: resp_valid[cur_id]=1, resp_ok=match. Increment ok_count (match) or rej_count (no match); each saturates at 16'hFFFF. Next state is IDLE.
- A request whose word equals the current SFR contents reports ok even if the write was rejected by the processor. This is intended: ok means "SFR holds requested config".
- Requests arriving while busy are not accepted; they wait in IDLE arbitration. No queueing inside the block.
- A requester dropping req_valid before acceptance is never granted; no response is issued.
- Requester g waits at most NUM_REQ-1 other grants (round-robin fairness).
- sfr_write_data keeps its last value outside WRITE; sfr_write and sfr_read are never high in the same cycle.

## Timing
- Reset (asynchronous assert, synchronous effect on release):
  - State IDLE, rr_ptr=0.
  - All strobes 0, resp_ok=0, busy=0.
  - sfr_write_data=0, cur_data=0, counters=0.
- Reset asserted mid-sequence: the sequence is abandoned immediately. No resp_valid is issued for it, and any pending strobe drops in the same cycle.
- Acceptance in cycle T (req_valid & req_ready):
  - sfr_write high in T+1.
  - sfr_read high in T+2.
  - Readback sampled at the end of cycle T+2+READ_LATENCY.
  - resp_valid high in T+3+READ_LATENCY.
  - IDLE (next req_ready possible) in T+4+READ_LATENCY.
- Throughput: one request per 4+READ_LATENCY cycles.
- Counters update on the edge ending the RESP cycle, visible from T+4+READ_LATENCY.
- busy high from T+1 through T+3+READ_LATENCY.

## Test plan
- Legal request, READ_LATENCY=1: req 0 sends 32'h0001_0008; model returns 32'h0001_0008.
  - req_ready[0] in T, sfr_write in T+1 with data 32'h0001_0008, sfr_read in T+2.
  - resp_valid[0]=1 with resp_ok=1 in T+4; ok_count=1.
- Illegal request: current SFR 32'h0001_0000; req 1 sends 32'h0003_0001; model leaves SFR unchanged.
  - resp_valid[1], resp_ok=0, rej_count=1.
- Contention: both requesters valid from reset with distinct legal words.
  - Grants alternate 0,1,0,1; each response goes to the matching requester; consecutive req_ready pulses are 5 cycles apart.
- Latency parameter: READ_LATENCY=3, model drives readback 3 cycles after sfr_read.
  - Sample taken at T+5, resp_valid in T+6; a readback value present only at T+3 must not be used.
- Reset mid-op: assert rst during WAIT.
  - All outputs 0 the same cycle; no resp_valid; after release, a pending req 1 is granted only after req 0 per rr_ptr=0.
- Saturation: force 65536 rejected requests.
  - rej_count stops at 16'hFFFF; ok_count unaffected.
